// File: rtl/reg_bank_mp.sv
// reg_bank_mp: multi-port configuration register bank.
// Each register has its own access mode (RW, RO, W1C, double-buffered).
// Writes are byte-strobed and have a one-cycle done/err handshake.
// There are NUM_RD independent one-cycle-latency read ports.
// The active image is exported flat on rego for datapath consumers.
module reg_bank_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 16,
  parameter int NUM_RD     = 2,
  parameter logic [DATA_DEPTH*DATA_WIDTH-1:0] RST_VALUE = '0,
  localparam int ADDR_WIDTH = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load_regs,
  input  logic [DATA_DEPTH*DATA_WIDTH-1:0] init_data,
  input  logic [2*DATA_DEPTH-1:0]          mode,
  input  logic                             commit,
  input  logic [DATA_DEPTH*DATA_WIDTH-1:0] hw_set,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic [DATA_WIDTH/8-1:0]          wr_strb,
  output logic                             wr_done,
  output logic                             wr_err,
  input  logic [NUM_RD-1:0]                rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]     rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]     rd_data,
  output logic [NUM_RD-1:0]                rd_valid,
  output logic [NUM_RD-1:0]                rd_err,
  output logic [DATA_DEPTH*DATA_WIDTH-1:0] rego
);

  localparam int NB = DATA_WIDTH / 8;
  // When the address space is exactly filled, every address is legal and the
  // range compare is omitted entirely.
  localparam bit LP_FULL = (DATA_DEPTH == (1 << ADDR_WIDTH));
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DATA_DEPTH);

  localparam logic [1:0] MODE_RW  = 2'b00;
  localparam logic [1:0] MODE_RO  = 2'b01;
  localparam logic [1:0] MODE_W1C = 2'b10;
  localparam logic [1:0] MODE_DB  = 2'b11;

  logic [DATA_WIDTH-1:0] w_strb_mask;
  logic [DATA_DEPTH-1:0] w_sel;
  logic [DATA_DEPTH-1:0] w_ro;
  logic                  w_wr_inrange;
  logic                  w_wr_ok;
  logic                  w_wr_bad;
  logic                  r_wr_done;
  logic                  r_wr_err;

  for (genvar gb = 0; gb < NB; gb++) begin : g_mask
    assign w_strb_mask[gb*8 +: 8] = {8{wr_strb[gb]}};
  end

  if (LP_FULL) begin : g_wr_full
    assign w_wr_inrange = 1'b1;
  end else begin : g_wr_part
    assign w_wr_inrange = ({1'b0, wr_addr} < LP_DEPTH);
  end

  // A write counts as accepted only when it hits a real register that is
  // not read-only, and it is not swallowed by a bulk load.
  assign w_wr_ok  = wr_en && !load_regs && w_wr_inrange && !(|(w_sel & w_ro));
  assign w_wr_bad = wr_en && !load_regs && (!w_wr_inrange || (|(w_sel & w_ro)));

  for (genvar gi = 0; gi < DATA_DEPTH; gi++) begin : g_reg
    logic [1:0]            w_mode;
    logic [DATA_WIDTH-1:0] w_act_nxt;
    logic [DATA_WIDTH-1:0] w_sh_nxt;
    logic [DATA_WIDTH-1:0] r_active;
    logic [DATA_WIDTH-1:0] r_shadow;

    assign w_mode    = mode[2*gi +: 2];
    assign w_sel[gi] = wr_en && (wr_addr == ADDR_WIDTH'(gi));
    assign w_ro[gi]  = (w_mode == MODE_RO);

    // Next active/shadow value: commit first, then the bus write, then the
    // hardware set last so that set beats a same-cycle W1C clear.
    always_comb begin
      w_act_nxt = r_active;
      w_sh_nxt  = r_shadow;
      if (commit && (w_mode == MODE_DB)) begin
        w_act_nxt = r_shadow;
      end
      if (w_sel[gi]) begin
        case (w_mode)
          MODE_RW:  w_act_nxt = (r_active & ~w_strb_mask) | (wr_data & w_strb_mask);
          MODE_DB:  w_sh_nxt  = (r_shadow & ~w_strb_mask) | (wr_data & w_strb_mask);
          MODE_W1C: w_act_nxt = r_active & ~(wr_data & w_strb_mask);
          default:  w_act_nxt = w_act_nxt;
        endcase
      end
      if (w_mode == MODE_W1C) begin
        w_act_nxt = w_act_nxt | hw_set[gi*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    // Register storage: reset image, then bulk load, then normal update.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_active <= RST_VALUE[gi*DATA_WIDTH +: DATA_WIDTH];
        r_shadow <= RST_VALUE[gi*DATA_WIDTH +: DATA_WIDTH];
      end else if (load_regs) begin
        r_active <= init_data[gi*DATA_WIDTH +: DATA_WIDTH];
        r_shadow <= init_data[gi*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        r_active <= w_act_nxt;
        r_shadow <= w_sh_nxt;
      end
    end

    assign rego[gi*DATA_WIDTH +: DATA_WIDTH] = r_active;
  end

  // Write handshake pulses, one cycle after the request is sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_done <= 1'b0;
      r_wr_err  <= 1'b0;
    end else begin
      r_wr_done <= w_wr_ok;
      r_wr_err  <= w_wr_bad;
    end
  end

  assign wr_done = r_wr_done;
  assign wr_err  = r_wr_err;

  for (genvar gp = 0; gp < NUM_RD; gp++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_inr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic                  r_rd_err;

    assign w_addr = rd_addr[gp*ADDR_WIDTH +: ADDR_WIDTH];

    if (LP_FULL) begin : g_full
      assign w_inr = 1'b1;
    end else begin : g_part
      assign w_inr = ({1'b0, w_addr} < LP_DEPTH);
    end

    // Read mux over the pre-edge active image; an illegal address selects
    // nothing and so yields zero.
    always_comb begin
      w_data = '0;
      for (int i = 0; i < DATA_DEPTH; i++) begin
        if (w_addr == ADDR_WIDTH'(i)) begin
          w_data = rego[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end

    // Read port: data holds between reads; an illegal-address read still
    // completes (valid) but flags err and returns zero.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rd_data  <= '0;
        r_rd_valid <= 1'b0;
        r_rd_err   <= 1'b0;
      end else begin
        r_rd_valid <= rd_en[gp];
        r_rd_err   <= rd_en[gp] && !w_inr;
        if (rd_en[gp]) begin
          r_rd_data <= w_data;
        end
      end
    end

    assign rd_data[gp*DATA_WIDTH +: DATA_WIDTH] = r_rd_data;
    assign rd_valid[gp] = r_rd_valid;
    assign rd_err[gp]   = r_rd_err;
  end

endmodule

// File: tb/tb_reg_bank_mp.sv
// Testbench for reg_bank_mp: directed scenarios followed by randomized
// traffic, all checked against an array-based model of the register bank.
// A 12-deep bank is used so that 4-bit addresses can name missing registers.
module tb_reg_bank_mp;

  localparam int DW = 32;
  localparam int DD = 12;
  localparam int NR = 2;
  localparam int AW = 4;
  localparam int FW = DD*DW;
  localparam logic [FW-1:0] RSTV = (FW'(32'hA5A5A5A5) << (3*DW)) | FW'(32'hDEADBEEF);

  logic            clk;
  logic            rst;
  logic            load_regs;
  logic [FW-1:0]   init_data;
  logic [2*DD-1:0] mode;
  logic            commit;
  logic [FW-1:0]   hw_set;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [DW/8-1:0] wr_strb;
  logic            wr_done;
  logic            wr_err;
  logic [NR-1:0]   rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]   rd_valid;
  logic [NR-1:0]   rd_err;
  logic [FW-1:0]   rego;

  reg_bank_mp #(.DATA_WIDTH(DW), .DATA_DEPTH(DD), .NUM_RD(NR), .RST_VALUE(RSTV)) dut (
    .clk(clk), .rst(rst), .load_regs(load_regs), .init_data(init_data),
    .mode(mode), .commit(commit), .hw_set(hw_set),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_done(wr_done), .wr_err(wr_err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_err(rd_err), .rego(rego)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_act [DD];
  logic [DW-1:0] m_sh  [DD];
  logic [DW-1:0] m_rd_data [NR];
  logic          m_wr_done, m_wr_err;
  logic [NR-1:0] m_rd_valid, m_rd_err;

  function automatic void model_reset();
    for (int i = 0; i < DD; i++) begin
      m_act[i] = RSTV[i*DW +: DW];
      m_sh[i]  = RSTV[i*DW +: DW];
    end
    for (int p = 0; p < NR; p++) m_rd_data[p] = '0;
    m_wr_done  = 1'b0;
    m_wr_err   = 1'b0;
    m_rd_valid = '0;
    m_rd_err   = '0;
  endfunction

  function automatic void model_step();
    logic [DW-1:0] old_act [DD];
    logic [DW-1:0] old_sh  [DD];
    int a;
    logic [1:0] md;
    logic legal;
    for (int i = 0; i < DD; i++) begin
      old_act[i] = m_act[i];
      old_sh[i]  = m_sh[i];
    end
    // reads see the image from before this edge
    for (int p = 0; p < NR; p++) begin
      a = int'(rd_addr[p*AW +: AW]);
      m_rd_valid[p] = rd_en[p];
      m_rd_err[p]   = rd_en[p] && (a >= DD);
      if (rd_en[p]) m_rd_data[p] = (a < DD) ? old_act[a] : '0;
    end
    a = int'(wr_addr);
    md = (a < DD) ? mode[2*a +: 2] : 2'b01;
    legal = (a < DD) && (md != 2'b01);
    m_wr_done = wr_en && !load_regs && legal;
    m_wr_err  = wr_en && !load_regs && !legal;
    if (load_regs) begin
      for (int i = 0; i < DD; i++) begin
        m_act[i] = init_data[i*DW +: DW];
        m_sh[i]  = init_data[i*DW +: DW];
      end
    end else begin
      for (int i = 0; i < DD; i++)
        if (commit && mode[2*i +: 2] == 2'b11) m_act[i] = old_sh[i];
      if (m_wr_done) begin
        for (int b = 0; b < DW/8; b++) begin
          if (wr_strb[b]) begin
            if (md == 2'b00)      m_act[a][8*b +: 8] = wr_data[8*b +: 8];
            else if (md == 2'b11) m_sh[a][8*b +: 8]  = wr_data[8*b +: 8];
            else                  m_act[a][8*b +: 8] = old_act[a][8*b +: 8] & ~wr_data[8*b +: 8];
          end
        end
      end
      for (int i = 0; i < DD; i++)
        if (mode[2*i +: 2] == 2'b10) m_act[i] = m_act[i] | hw_set[i*DW +: DW];
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    logic [FW-1:0]    e_rego;
    logic [NR*DW-1:0] e_rd;
    #2;
    for (int i = 0; i < DD; i++) e_rego[i*DW +: DW] = m_act[i];
    for (int p = 0; p < NR; p++) e_rd[p*DW +: DW] = m_rd_data[p];
    chk("rego",     rego,                 e_rego);
    chk("wr_done",  FW'(wr_done),         FW'(m_wr_done));
    chk("wr_err",   FW'(wr_err),          FW'(m_wr_err));
    chk("rd_valid", FW'(rd_valid),        FW'(m_rd_valid));
    chk("rd_err",   FW'(rd_err),          FW'(m_rd_err));
    chk("rd_data",  FW'(rd_data),         FW'(e_rd));
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    load_regs = 1'b0;
    commit    = 1'b0;
    hw_set    = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    wr_strb   = '0;
    rd_en     = '0;
    rd_addr   = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic next();
    @(negedge clk);
    idle();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    init_data = '0;
    mode = '0;
    mode[2*4 +: 2] = 2'b01;
    mode[2*5 +: 2] = 2'b10;
    mode[2*7 +: 2] = 2'b11;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_reg3",  FW'(rego[3*DW +: DW]), FW'(32'hA5A5A5A5));
    chk("rst_model", FW'(m_act[3]),         FW'(32'hA5A5A5A5));
    chk("rst_done",  FW'(wr_done),          FW'(1'b0));

    // bulk load
    @(negedge clk);
    rst = 1'b0;
    load_regs = 1'b1;
    init_data[3*DW +: DW] = 32'h1;
    init_data[2*DW +: DW] = 32'h11223344;
    init_data[4*DW +: DW] = 32'h11223344;
    init_data[5*DW +: DW] = 32'hF0;
    tick();
    chk("load_reg3", FW'(rego[3*DW +: DW]), FW'(32'h1));

    // RW byte-strobed write
    next(); wr(4'd2, 32'hAABBCCDD, 4'b0101); tick();
    chk("rw_reg2",  FW'(rego[2*DW +: DW]), FW'(32'h11BB33DD));
    chk("rw_model", FW'(m_act[2]),         FW'(32'h11BB33DD));
    chk("rw_done",  FW'(wr_done),          FW'(1'b1));

    // RO write rejected
    next(); wr(4'd4, 32'hAABBCCDD, 4'b0101); tick();
    chk("ro_err",  FW'(wr_err),            FW'(1'b1));
    chk("ro_reg4", FW'(rego[4*DW +: DW]),  FW'(32'h11223344));

    // out-of-range write rejected
    next(); wr(4'd13, 32'h12345678, 4'hF); tick();
    chk("oor_err", FW'(wr_err), FW'(1'b1));

    // W1C clear with simultaneous set
    next(); wr(4'd5, 32'h30, 4'hF); hw_set[5*DW +: DW] = 32'h10; tick();
    chk("w1c_reg5",  FW'(rego[5*DW +: DW]), FW'(32'hD0));
    chk("w1c_model", FW'(m_act[5]),         FW'(32'hD0));

    // double-buffered register
    next(); wr(4'd7, 32'h55, 4'hF); tick();
    chk("db_hold", FW'(rego[7*DW +: DW]), FW'(32'h0));
    next(); wr(4'd7, 32'h66, 4'hF); commit = 1'b1; tick();
    chk("db_commit1", FW'(rego[7*DW +: DW]), FW'(32'h55));
    next(); commit = 1'b1; tick();
    chk("db_commit2", FW'(rego[7*DW +: DW]), FW'(32'h66));

    // same-cycle read/write on both ports
    next(); rd_en = 2'b11; rd_addr = {4'd2, 4'd2}; wr(4'd2, 32'h12345678, 4'hF); tick();
    chk("rd_old_p0", FW'(rd_data[0 +: DW]),  FW'(32'h11BB33DD));
    chk("rd_old_p1", FW'(rd_data[DW +: DW]), FW'(32'h11BB33DD));
    chk("rd_vld2",   FW'(rd_valid),          FW'(2'b11));
    next(); rd_en = 2'b11; rd_addr = {4'd14, 4'd2}; tick();
    chk("rd_new_p0", FW'(rd_data[0 +: DW]),  FW'(32'h12345678));
    chk("rd_err_p1", FW'(rd_err),            FW'(2'b10));
    chk("rd_zero_p1", FW'(rd_data[DW +: DW]), FW'(32'h0));

    // reset during activity
    @(negedge clk);
    wr(4'd2, 32'hFFFFFFFF, 4'hF); rd_en = 2'b11; rst = 1'b1;
    #1;
    chk("arst_vld",   FW'(rd_valid), FW'(2'b00));
    chk("arst_rdata", FW'(rd_data),  FW'(0));
    tick();
    chk("arst_rego", rego,          RSTV);
    chk("arst_done", FW'(wr_done),  FW'(1'b0));
    next(); rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < DD; i++) mode[2*i +: 2] = 2'($urandom_range(0, 3));
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      idle();
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0)
        for (int i = 0; i < DD; i++) mode[2*i +: 2] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) begin
        load_regs = 1'b1;
        for (int i = 0; i < DD; i++) init_data[i*DW +: DW] = $urandom;
      end
      commit  = ($urandom_range(0, 7) == 0);
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom_range(0, 15));
      wr_data = $urandom;
      wr_strb = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < DD; i++) hw_set[i*DW +: DW] = $urandom & $urandom & $urandom;
      rd_en   = NR'($urandom_range(0, 3));
      rd_addr = (NR*AW)'($urandom_range(0, 255));
    end
    next();
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
